time_set_control: RTL and testbench
===================================

TIME_SET_CONTROL -- requirements
Module: time_set_control

Interface
REQ-001 SHALL have parameter REPEAT_BITS, default 18, auto-repeat period exponent (period = 2^REPEAT_BITS clocks).
REQ-002 SHALL have parameter BLINK_BITS, default 23, blink half-period exponent (half-period = 2^BLINK_BITS clocks).
REQ-003 SHALL have parameter IDLE_BITS, default 28, idle-timeout exponent (timeout = 2^IDLE_BITS clocks).
REQ-004 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mode_press  input  1  one-clock pulse, short press on the mode button.
REQ-007 SHALL have port mode_long  input  1  one-clock pulse, long press on the mode button.
REQ-008 SHALL have port adj_press  input  1  one-clock pulse, short press on the adjust button.
REQ-009 SHALL have port adj_long  input  1  one-clock pulse, long press on the adjust button.
REQ-010 SHALL have port adj_level  input  1  debounced adjust level, active low (0 = held).
REQ-011 SHALL have port run_enable  output  1  high while the timekeeper is permitted to count.
REQ-012 SHALL have port field  output  2  field under edit: 0 none, 1 hour, 2 minute, 3 second.
REQ-013 SHALL have port inc_hour, inc_min, inc_sec  output  1 each  one-clock increment pulses to the timekeeper.
REQ-014 SHALL have port blink  output  1  display blank strobe for the edited field.

Function
REQ-015 SHALL implement states RUN, SET_HOUR, SET_MIN, SET_SEC; field = 0/1/2/3 respectively; run_enable = 1 only in RUN.
REQ-016 RUN: mode_long -> SET_HOUR; mode_press, adj_press, adj_long SHALL be ignored.
REQ-017 In SET_x: mode_press -> next field (HOUR->MIN->SEC->RUN); mode_long -> RUN from any SET state.
REQ-018 In SET_x: adj_press SHALL produce exactly one pulse on the inc_* output matching the current field, registered, asserted the clock after the input pulse.
REQ-019 In SET_x: adj_long SHALL arm auto-repeat, emitting one immediate inc pulse (same latency as REQ-018), then one pulse every 2^REPEAT_BITS clocks while adj_level = 0.
REQ-020 Auto-repeat SHALL disarm on adj_level = 1, any state change, or reset; the repeat counter SHALL clear to 0 on arming.
REQ-021 Same-cycle mode and adj events: the mode event wins; the adj event is dropped; auto-repeat disarms.
REQ-022 adj_press and adj_long in the same cycle SHALL be treated as adj_long.
REQ-023 At most one inc_* output SHALL be high in any cycle; all inc_* SHALL be 0 in RUN.
REQ-024 blink SHALL toggle every 2^BLINK_BITS clocks in SET states, restart at 0 on every state entry, and be 0 in RUN.
REQ-025 blink SHALL be forced to 0 while auto-repeat is armed, so the value being changed stays visible.
REQ-026 The idle counter SHALL clear on any input pulse or while adj_level = 0.
REQ-027 In SET_x, the idle counter reaching 2^IDLE_BITS-1 SHALL force RUN on the next clock with no inc pulse.
REQ-028 All counters SHALL be unsigned, wrap-free, and sized exactly to their exponent plus one bit where terminal detection requires it.

Reset
REQ-029 On reset: state = RUN, run_enable = 1, field = 0, inc_* = 0, blink = 0, auto-repeat disarmed, all counters = 0.
REQ-030 Reset asserted mid-edit or mid-repeat SHALL abort immediately with no trailing inc pulse after deassertion.

Structure
REQ-031 State encodings and field codes SHALL reside in a shared header of localparams, also used by the display mux and timekeeper.
REQ-032 A single sub-module, rate_tick (parameterised divider with clear input and terminal pulse output), SHALL be instantiated for repeat, blink and idle timing.

Verification (REPEAT_BITS=3, BLINK_BITS=2, IDLE_BITS=5)
REQ-033 reset, then adj_press -> run_enable = 1, field = 0, no inc pulses.
REQ-034 mode_long, then adj_press twice -> field = 1, exactly 2 inc_hour pulses, each 1 clock after its input.
REQ-035 In SET_MIN: adj_long, then adj_level = 0 for 20 clocks -> inc_min at +1, +9, +17; none after adj_level = 1.
REQ-036 In SET_SEC: mode_press and adj_press in the same cycle -> RUN, no inc_sec.
REQ-037 In SET_HOUR: no input for 32 clocks -> RUN, field = 0, blink = 0.
REQ-038 Reset asserted during auto-repeat -> all outputs at reset values within the same cycle; no inc pulse after release.

Source files
------------

// File: rtl/time_set_control_pkg.sv
// Shared state and field codes for the time-set controller,
// display mux and timekeeper.
package time_set_control_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_SET_HOUR = 2'd1;
  localparam state_t ST_SET_MIN  = 2'd2;
  localparam state_t ST_SET_SEC  = 2'd3;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HOUR = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  function automatic logic [1:0] field_of(input state_t s);
    unique case (s)
      ST_SET_HOUR: return FLD_HOUR;
      ST_SET_MIN:  return FLD_MIN;
      ST_SET_SEC:  return FLD_SEC;
      default:     return FLD_NONE;
    endcase
  endfunction

  // one-hot {hour, min, sec}
  function automatic logic [2:0] inc_of(input state_t s);
    unique case (s)
      ST_SET_HOUR: return 3'b100;
      ST_SET_MIN:  return 3'b010;
      ST_SET_SEC:  return 3'b001;
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/time_set_control_if.sv
// Button events in, edit status and increment
// strobes out.
interface time_set_control_if;
  logic       mode_press;
  logic       mode_long;
  logic       adj_press;
  logic       adj_long;
  logic       adj_level;
  logic       run_enable;
  logic [1:0] field;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_sec;
  logic       blink;

  modport master (
    output mode_press, mode_long,
    output adj_press, adj_long, adj_level,
    input  run_enable, field, blink,
    input  inc_hour, inc_min, inc_sec
  );

  modport slave (
    input  mode_press, mode_long,
    input  adj_press, adj_long, adj_level,
    output run_enable, field, blink,
    output inc_hour, inc_min, inc_sec
  );
endinterface

// File: rtl/time_set_control_rate_tick.sv
// Free-running divider: pulses tick on the last
// count of a 2^BITS period while enabled.
module rate_tick #(
  parameter int BITS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [BITS-1:0] cnt;

  assign tick = en && (cnt == '1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/time_set_control.sv
// Mode/adjust button sequencer for setting the
// clock: field select, increments, blink, timeout.
module time_set_control #(
  parameter int REPEAT_BITS = 18,
  parameter int BLINK_BITS  = 23,
  parameter int IDLE_BITS   = 28
) (
  input  logic clock,
  input  logic reset,
  time_set_control_if.slave bus
);
  import time_set_control_pkg::*;

  state_t     state;
  state_t     next_state;
  logic       armed;
  logic       blink_q;
  logic [2:0] inc_q;
  logic       in_set;
  logic       chg;
  logic       any_pulse;
  logic       adj_ev;
  logic       arm_set;
  logic       rep_ev;
  logic       fire;
  logic       rep_tick;
  logic       blink_tick;
  logic       idle_tick;

  assign in_set    = (state != ST_RUN);
  assign chg       = (next_state != state);
  assign any_pulse = bus.mode_press | bus.mode_long
                   | bus.adj_press  | bus.adj_long;

  // adj events only count when the state holds
  assign adj_ev  = in_set && !chg
                && (bus.adj_press || bus.adj_long);
  assign arm_set = in_set && !chg && bus.adj_long;
  assign rep_ev  = armed && !chg && rep_tick
                && !bus.adj_level;
  assign fire    = adj_ev || rep_ev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_RUN: begin
        if (bus.mode_long) next_state = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (bus.mode_long)       next_state = ST_RUN;
        else if (bus.mode_press) next_state = ST_SET_MIN;
        else if (idle_tick)      next_state = ST_RUN;
      end
      ST_SET_MIN: begin
        if (bus.mode_long)       next_state = ST_RUN;
        else if (bus.mode_press) next_state = ST_SET_SEC;
        else if (idle_tick)      next_state = ST_RUN;
      end
      ST_SET_SEC: begin
        if (bus.mode_long)       next_state = ST_RUN;
        else if (bus.mode_press) next_state = ST_RUN;
        else if (idle_tick)      next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_comb begin
    bus.run_enable = (state == ST_RUN);
    bus.field      = field_of(state);
    bus.inc_hour   = inc_q[2];
    bus.inc_min    = inc_q[1];
    bus.inc_sec    = inc_q[0];
    bus.blink      = in_set && blink_q && !armed;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed   <= 1'b0;
      blink_q <= 1'b0;
      inc_q   <= 3'b000;
    end else begin
      if (chg)                armed <= 1'b0;
      else if (arm_set)       armed <= 1'b1;
      else if (bus.adj_level) armed <= 1'b0;

      if (chg)             blink_q <= 1'b0;
      else if (blink_tick) blink_q <= ~blink_q;

      inc_q <= fire ? inc_of(state) : 3'b000;
    end
  end

  rate_tick #(.BITS(REPEAT_BITS)) u_rep (
    .clock (clock),
    .reset (reset),
    .en    (armed),
    .clr   (arm_set || !armed),
    .tick  (rep_tick)
  );

  rate_tick #(.BITS(BLINK_BITS)) u_blink (
    .clock (clock),
    .reset (reset),
    .en    (in_set),
    .clr   (chg || !in_set),
    .tick  (blink_tick)
  );

  rate_tick #(.BITS(IDLE_BITS)) u_idle (
    .clock (clock),
    .reset (reset),
    .en    (in_set),
    .clr   (any_pulse || !bus.adj_level || !in_set),
    .tick  (idle_tick)
  );

endmodule

// File: tb/tb_time_set_control.sv
// Randomised scoreboard bench for time_set_control
// against a timestamp-based reference model.
module tb_time_set_control;

  localparam int RB   = 3;
  localparam int BB   = 2;
  localparam int IB   = 5;
  localparam int RPER = 1 << RB;
  localparam int IDLE = 1 << IB;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  time_set_control_if bus();

  time_set_control #(
    .REPEAT_BITS (RB),
    .BLINK_BITS  (BB),
    .IDLE_BITS   (IB)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int f;
  } pulse_t;

  typedef struct {
    int cyc;
    int f;
    bit run;
    bit blk;
  } stat_t;

  pulse_t pq[$];
  stat_t  sq[$];

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  // model: current field, repeat arm time,
  // field entry time, last idle-clearing cycle
  int m_s       = 0;
  bit m_arm     = 1'b0;
  int m_arm_cyc = 0;
  int m_entry   = 0;
  int m_clr     = 0;

  task automatic model(input bit mp, input bit ml,
                       input bit ap, input bit al,
                       input bit lv);
    int     t;
    int     ns;
    bit     ins;
    bit     chg;
    bit     tmo;
    bit     fire;
    stat_t  s;
    pulse_t p;
    t   = cyc;
    ins = (m_s != 0);
    s.cyc = t;
    s.f   = m_s;
    s.run = !ins;
    s.blk = ins && !m_arm
         && ((((t - m_entry) >> BB) & 1) != 0);
    sq.push_back(s);
    tmo = ins && ((t - m_clr) == IDLE);
    ns  = m_s;
    if (!ins) begin
      if (ml) ns = 1;
    end else if (ml) ns = 0;
    else if (mp)     ns = (m_s == 3) ? 0 : m_s + 1;
    else if (tmo)    ns = 0;
    chg = (ns != m_s);
    if (ins && !chg) begin
      fire = ap || al
          || (m_arm && !lv
              && ((t - m_arm_cyc) % RPER) == 0);
      if (fire) begin
        p.cyc = t + 1;
        p.f   = m_s;
        pq.push_back(p);
      end
    end
    if (chg) m_arm = 1'b0;
    else if (ins && al) begin
      m_arm     = 1'b1;
      m_arm_cyc = t;
    end else if (lv) m_arm = 1'b0;
    if (chg) m_entry = t + 1;
    if (mp || ml || ap || al || !lv || !ins) m_clr = t;
    m_s = ns;
  endtask

  task automatic step(input bit mp, input bit ml,
                      input bit ap, input bit al,
                      input bit lv);
    @(posedge clk);
    #1;
    cyc++;
    bus.mode_press = mp;
    bus.mode_long  = ml;
    bus.adj_press  = ap;
    bus.adj_long   = al;
    bus.adj_level  = lv;
    model(mp, ml, ap, al, lv);
  endtask

  task automatic idle(input int n, input bit lv);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, lv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.run_enable === 1'b1 && bus.field === 2'd0
        && bus.inc_hour === 1'b0 && bus.inc_min === 1'b0
        && bus.inc_sec === 1'b0 && bus.blink === 1'b0)
      passed++;
    else
      $display("FAIL reset_outputs cyc=%0d run=%b field=%0d inc=%b%b%b blink=%b want run=1 field=0 inc=000 blink=0",
               cyc, bus.run_enable, bus.field, bus.inc_hour,
               bus.inc_min, bus.inc_sec, bus.blink);
    pq.delete();
    m_s   = 0;
    m_arm = 1'b0;
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  stat_t  ms;
  pulse_t mpl;
  int     nh;
  int     gf;

  always @(negedge clk) begin
    if (sq.size() > 0) begin
      ms = sq.pop_front();
      total++;
      if (int'(bus.field) == ms.f
          && bus.run_enable == ms.run
          && bus.blink == ms.blk)
        passed++;
      else
        $display("FAIL status cyc=%0d field=%0d want %0d run=%b want %b blink=%b want %b",
                 cyc, bus.field, ms.f, bus.run_enable, ms.run,
                 bus.blink, ms.blk);
    end
    nh = int'(bus.inc_hour) + int'(bus.inc_min)
       + int'(bus.inc_sec);
    gf = bus.inc_hour ? 1 : bus.inc_min ? 2
       : bus.inc_sec ? 3 : 0;
    if (nh != 0) begin
      total++;
      if (pq.size() == 0)
        $display("FAIL inc_unexpected cyc=%0d got field %0d want none",
                 cyc, gf);
      else begin
        mpl = pq.pop_front();
        if (mpl.cyc == cyc && nh == 1 && gf == mpl.f)
          passed++;
        else
          $display("FAIL inc_pulse cyc=%0d field=%0d count=%0d want cyc=%0d field=%0d count=1",
                   cyc, gf, nh, mpl.cyc, mpl.f);
      end
    end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
      total++;
      mpl = pq.pop_front();
      $display("FAIL inc_missing cyc=%0d got none want field %0d",
               cyc, mpl.f);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit lv;
    rst            = 1'b1;
    bus.mode_press = 1'b0;
    bus.mode_long  = 1'b0;
    bus.adj_press  = 1'b0;
    bus.adj_long   = 1'b0;
    bus.adj_level  = 1'b1;
    idle(2, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // adjust ignored in RUN
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    idle(3, 1);

    // two hour increments
    step(0, 1, 0, 0, 1);
    idle(2, 1);
    step(0, 0, 1, 0, 1);
    idle(3, 1);
    step(0, 0, 1, 0, 1);
    idle(3, 1);

    // auto-repeat in SET_MIN for 20 clocks
    step(1, 0, 0, 0, 1);
    idle(2, 1);
    step(0, 0, 0, 1, 0);
    idle(19, 0);
    idle(14, 1);

    // mode beats adjust in SET_SEC
    step(1, 0, 0, 0, 1);
    idle(2, 1);
    step(1, 0, 1, 0, 1);
    idle(3, 1);

    // idle timeout from SET_HOUR
    step(0, 1, 0, 0, 1);
    idle(40, 1);

    // press + long together, then mode_long abort
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 0);
    idle(10, 0);
    step(0, 1, 0, 1, 0);
    idle(10, 1);

    // reset mid-repeat
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    idle(12, 0);
    do_reset();
    idle(20, 1);

    lv = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, ((i / 200) % 2) ? 999 : 99));
      if ($urandom_range(0, 15) == 0) lv = ~lv;
      if ($urandom_range(0, 299) == 0) do_reset();
      else
        step(r < 4 || r == 17,
             r >= 4 && r < 7,
             (r >= 7 && r < 13) || r == 16 || r == 17,
             (r >= 13 && r < 16) || r == 16,
             lv);
    end

    idle(12, 1);
    @(negedge clk);
    #2;
    total++;
    if (pq.size() == 0) passed++;
    else
      $display("FAIL pending_pulses got %0d left want 0", pq.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
